mem_responder: RTL and testbench

- Memory-side responder for the core's fetch/load/store port. Accepts one request at a time over a valid/ready handshake and holds a word-organised storage array.
- Applies byte-masked writes and returns read data after a fixed, parameterised latency over a second valid/ready handshake.
- Replaces the zero-latency combinational memory model, so the core can be exercised against multi-cycle memory.

---
 rtl/mem_responder_if.sv | 27 ++
 rtl/mem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory port and mem_responder.
// The core side uses the master modport, the responder the slave modport.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_wen;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wmask;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency, word-organised memory responder with byte-masked writes.
// Define MEM_RESPONDER_MISALIGN_ERR_EN to reject addresses that are not word aligned.
module mem_responder #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h0000_0000_8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_responder_if.slave    bus
);

  localparam int BYTES      = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam int SPAN_LOG2  = DEPTH_LOG2 + BYTE_SHIFT;
  localparam int WORDS      = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } stateE;

  stateE                   stateReg;
  stateE                   stateNext;
  logic [3:0]              latCntReg;
  logic [3:0]              latCntNext;
  logic                    accept;
  logic                    enterResp;

  logic [ADDR_WIDTH-1:0]   addrReg;
  logic                    wenReg;
  logic [DATA_WIDTH-1:0]   wdataReg;
  logic [BYTES-1:0]        wmaskReg;

  logic [ADDR_WIDTH-1:0]   commitAddr;
  logic                    commitWen;
  logic [DATA_WIDTH-1:0]   commitWdata;
  logic [BYTES-1:0]        commitWmask;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [DEPTH_LOG2-1:0]   wordIndex;
  logic                    inRange;
  logic                    commitOk;
  logic                    memWrite;

  logic                    reqReadyReg;
  logic                    respValidReg;
  logic [DATA_WIDTH-1:0]   respRdataReg;
  logic                    respErrReg;

  logic [DATA_WIDTH-1:0]   mem [0:WORDS-1];

  function automatic logic [DATA_WIDTH-1:0] mergeBytes(
    input logic [DATA_WIDTH-1:0] oldWord,
    input logic [DATA_WIDTH-1:0] newWord,
    input logic [BYTES-1:0]      mask
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = oldWord;
    for (int i = 0; i < BYTES; i++) begin
      if (mask[i]) begin
        merged[8*i +: 8] = newWord[8*i +: 8];
      end else begin
        merged[8*i +: 8] = oldWord[8*i +: 8];
      end
    end
    return merged;
  endfunction

  // Next-state and latency-counter logic.
  always_comb begin
    stateNext  = stateReg;
    latCntNext = latCntReg;
    accept     = 1'b0;
    case (stateReg)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            stateNext  = RESP;
            latCntNext = 4'd0;
          end else begin
            stateNext  = BUSY;
            latCntNext = LAT_INIT;
          end
        end else begin
          stateNext  = IDLE;
          latCntNext = 4'd0;
        end
      end
      BUSY: begin
        // A zero count can only come from corruption; leave rather than wrap.
        if (latCntReg <= 4'd1) begin
          stateNext  = RESP;
          latCntNext = 4'd0;
        end else begin
          stateNext  = BUSY;
          latCntNext = latCntReg - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          stateNext = IDLE;
        end else begin
          stateNext = RESP;
        end
        latCntNext = 4'd0;
      end
      default: begin
        stateNext  = IDLE;
        latCntNext = 4'd0;
      end
    endcase
  end

  // Commit operands: with single-cycle latency the commit edge is the accept edge.
  always_comb begin
    if (stateReg == IDLE) begin
      commitAddr  = bus.req_addr;
      commitWen   = bus.req_wen;
      commitWdata = bus.req_wdata;
      commitWmask = bus.req_wmask;
    end else begin
      commitAddr  = addrReg;
      commitWen   = wenReg;
      commitWdata = wdataReg;
      commitWmask = wmaskReg;
    end
  end

  // Range and alignment decode; a wrapped subtraction lands far out of range.
  always_comb begin
    offset    = commitAddr - BASE_ADDR;
    wordIndex = offset[SPAN_LOG2-1:BYTE_SHIFT];
    inRange   = ((offset >> SPAN_LOG2) == {ADDR_WIDTH{1'b0}});
`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
    commitOk  = inRange && (commitAddr[BYTE_SHIFT-1:0] == {BYTE_SHIFT{1'b0}});
`else
    commitOk  = inRange;
`endif
    enterResp = (stateNext == RESP) && (stateReg != RESP);
    memWrite  = rst && enterResp && commitOk && commitWen;
  end

  // State, counter and request latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateReg  <= IDLE;
      latCntReg <= 4'd0;
      addrReg   <= {ADDR_WIDTH{1'b0}};
      wenReg    <= 1'b0;
      wdataReg  <= {DATA_WIDTH{1'b0}};
      wmaskReg  <= {BYTES{1'b0}};
    end else begin
      stateReg  <= stateNext;
      latCntReg <= latCntNext;
      if (accept) begin
        addrReg  <= bus.req_addr;
        wenReg   <= bus.req_wen;
        wdataReg <= bus.req_wdata;
        wmaskReg <= bus.req_wmask;
      end
    end
  end

  // Registered handshake outputs and response payload.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reqReadyReg  <= 1'b1;
      respValidReg <= 1'b0;
      respRdataReg <= {DATA_WIDTH{1'b0}};
      respErrReg   <= 1'b0;
    end else begin
      reqReadyReg  <= (stateNext == IDLE);
      respValidReg <= (stateNext == RESP);
      if (enterResp) begin
        if (commitOk) begin
          respRdataReg <= mem[wordIndex];
          respErrReg   <= 1'b0;
        end else begin
          respRdataReg <= {DATA_WIDTH{1'b0}};
          respErrReg   <= 1'b1;
        end
      end
    end
  end

  // Storage keeps its contents across reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (memWrite) begin
      mem[wordIndex] <= mergeBytes(mem[wordIndex], commitWdata, commitWmask);
    end
  end

  assign bus.req_ready  = reqReadyReg;
  assign bus.resp_valid = respValidReg;
  assign bus.resp_rdata = respRdataReg;
  assign bus.resp_err   = respErrReg;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: predictions are queued when a request
// is driven and compared when the matching response appears.
module tb_mem_responder;

  localparam int          AW      = 64;
  localparam int          DW      = 64;
  localparam int          LATENCY = 2;
  localparam logic [63:0] BASE    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SPAN    = 64'h0000_0000_0000_8000;

  typedef struct {
    logic [63:0] data;
    logic        err;
    bit          chkData;
  } expT;

  logic clk;
  logic rst;
  int   nChecks;
  int   nPass;
  expT  sbQ[$];
  logic [63:0] model [int];

  mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(12),
    .BASE_ADDR (BASE),
    .LATENCY   (LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic expT predict(input logic [63:0] addr, input logic wen,
                                  input logic [63:0] wdata, input logic [7:0] wmask);
    expT e;
    bit ok;
    int idx;
    logic [63:0] w;
    ok = (addr >= BASE) && (addr < BASE + SPAN);
`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
    ok = ok && (addr[2:0] == 3'd0);
`endif
    if (!ok) begin
      e.data = 64'd0; e.err = 1'b1; e.chkData = 1'b1;
      return e;
    end
    idx = int'((addr - BASE) >> 3);
    e.err = 1'b0;
    e.chkData = model.exists(idx);
    e.data = e.chkData ? model[idx] : 64'd0;
    if (wen) begin
      if (model.exists(idx) || wmask == 8'hFF) begin
        w = model.exists(idx) ? model[idx] : 64'd0;
        for (int b = 0; b < 8; b++) begin
          if (wmask[b]) w[8*b +: 8] = wdata[8*b +: 8];
        end
        model[idx] = w;
      end else begin
        model.delete(idx);
      end
    end
    return e;
  endfunction

  // Drive one request (called at a negedge), hold resp_ready low for 'hold' cycles.
  task automatic doReq(input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
                       input logic [7:0] wmask, input int hold);
    expT e;
    int cyc;
    int lat;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_wen   = wen;
    bus.req_wdata = wdata;
    bus.req_wmask = wmask;
    sbQ.push_back(predict(addr, wen, wdata, wmask));
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20) begin
      checkVal("accept_timeout", 64'd0, 64'd1);
      bus.req_valid = 1'b0;
      void'(sbQ.pop_front());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = {$urandom, $urandom};
    bus.req_wen   = 1'($urandom);
    bus.req_wdata = {$urandom, $urandom};
    bus.req_wmask = 8'($urandom);
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) begin
      checkVal("resp_timeout", 64'd0, 64'd1);
      void'(sbQ.pop_front());
      return;
    end
    checkVal("latency", 64'(lat), 64'(LATENCY));
    e = sbQ.pop_front();
    for (int k = 0; k < hold; k++) begin
      checkVal("hold_valid", 64'(bus.resp_valid), 64'd1);
      checkVal("hold_ready", 64'(bus.req_ready), 64'd0);
      if (e.chkData) checkVal("hold_rdata", bus.resp_rdata, e.data);
      @(negedge clk);
    end
    if (e.chkData) checkVal("rdata", bus.resp_rdata, e.data);
    checkVal("err", 64'(bus.resp_err), 64'(e.err));
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    checkVal("idle_ready", 64'(bus.req_ready), 64'd1);
    checkVal("idle_valid", 64'(bus.resp_valid), 64'd0);
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    rst = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 64'd0;
    bus.req_wen    = 1'b0;
    bus.req_wdata  = 64'd0;
    bus.req_wmask  = 8'd0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("rst_ready", 64'(bus.req_ready), 64'd1);
    checkVal("rst_valid", 64'(bus.resp_valid), 64'd0);
    checkVal("rst_rdata", bus.resp_rdata, 64'd0);
    checkVal("rst_err", 64'(bus.resp_err), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    checkVal("post_rst_ready", 64'(bus.req_ready), 64'd1);

    doReq(64'h8000_0008, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 0);
    doReq(64'h8000_0008, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0);
    doReq(64'h8000_0008, 1'b0, 64'd0, 8'h00, 5);

    doReq(64'h8000_0000, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
    doReq(64'h7FFF_FFF8, 1'b0, 64'd0, 8'h00, 0);
    doReq(64'h8000_8000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    doReq(64'h8000_0000, 1'b0, 64'd0, 8'h00, 0);
    doReq(64'h8000_7FF8, 1'b1, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 0);
    doReq(64'h8000_7FF8, 1'b1, 64'd0, 8'h00, 0);
    doReq(64'h8000_7FF8, 1'b0, 64'd0, 8'h00, 1);

    // Abandon a write by asserting reset while it is in flight.
    doReq(64'h8000_0010, 1'b1, 64'h5555_6666_7777_8888, 8'hFF, 0);
    bus.req_valid = 1'b1;
    bus.req_addr  = 64'h8000_0010;
    bus.req_wen   = 1'b1;
    bus.req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
    bus.req_wmask = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checkVal("midrst_valid", 64'(bus.resp_valid), 64'd0);
    checkVal("midrst_ready", 64'(bus.req_ready), 64'd1);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkVal("midrst_no_resp", 64'(bus.resp_valid), 64'd0);
    end
    doReq(64'h8000_0010, 1'b0, 64'd0, 8'h00, 0);

    doReq(64'h8000_0009, 1'b0, 64'd0, 8'h00, 0);

    for (int w = 0; w < 16; w++) begin
      doReq(BASE + 64'(w * 8), 1'b1, {$urandom, $urandom}, 8'hFF, 0);
    end
    for (int t = 0; t < 24; t++) begin
      doReq(BASE + 64'($urandom_range(0, 15) * 8), 1'($urandom), {$urandom, $urandom},
            8'($urandom), int'($urandom_range(0, 2)));
    end

    checkVal("sb_empty", 64'(sbQ.size()), 64'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
